// File: rtl/cam_capture.sv
// Camera capture stage: rebuilds RGB565 pixels from the sensor byte stream,
// tags them with X/Y, and reports frame/line strobes and geometry errors.
module cam_capture #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int SKIP_FRAMES = 2
) (
    input  logic        PCLK,
    input  logic        reset,
    input  logic        enable,
    input  logic        VSYNC,
    input  logic        HREF,
    input  logic [7:0]  DATA,
    output logic        pix_valid,
    output logic [15:0] pix_data,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic        frame_start,
    output logic        frame_done,
    output logic        line_end,
    output logic        err_line,
    output logic        err_frame,
    output logic [15:0] frame_cnt
);

    localparam int SKIP_W = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
    localparam logic [SKIP_W-1:0] SKIP_INIT = SKIP_W'(SKIP_FRAMES);
    localparam logic [9:0] H_LIM = 10'(H_ACTIVE);
    localparam logic [8:0] V_LIM = 9'(V_ACTIVE);

    typedef enum logic [1:0] {SYNC, BLANK, FRAME} state_t;

    state_t            state;
    logic              vs_d;
    logic              href_d;
    logic [SKIP_W-1:0] skip_cnt;
    logic              capture;
    logic              phase;
    logic [7:0]        hi;
    logic [9:0]        x;
    logic [8:0]        y;

    logic       vs_rise;
    logic       vs_fall;
    logic       href_fall;
    logic [9:0] x_inc;
    logic [8:0] y_inc;
    logic [8:0] y_end;

    assign vs_rise   = VSYNC & ~vs_d;
    assign vs_fall   = ~VSYNC & vs_d;
    assign href_fall = ~HREF & href_d;
    assign x_inc     = (x == 10'h3FF) ? x : x + 10'd1;
    assign y_inc     = (y == 9'h1FF) ? y : y + 9'd1;
    // A line ending on the same edge as the frame counts toward the frame check.
    assign y_end     = href_fall ? y_inc : y;

    always_ff @(posedge PCLK) begin
        if (reset) begin
            state       <= SYNC;
            vs_d        <= 1'b0;
            href_d      <= 1'b0;
            skip_cnt    <= SKIP_INIT;
            capture     <= 1'b0;
            phase       <= 1'b0;
            hi          <= 8'd0;
            x           <= 10'd0;
            y           <= 9'd0;
            pix_valid   <= 1'b0;
            pix_data    <= 16'd0;
            pix_x       <= 10'd0;
            pix_y       <= 9'd0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            line_end    <= 1'b0;
            err_line    <= 1'b0;
            err_frame   <= 1'b0;
            frame_cnt   <= 16'd0;
        end else begin
            vs_d        <= VSYNC;
            href_d      <= HREF;
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            line_end    <= 1'b0;

            case (state)
                SYNC: begin
                    if (vs_rise) state <= BLANK;
                end

                BLANK: begin
                    if (vs_fall) begin
                        state <= FRAME;
                        x     <= 10'd0;
                        y     <= 9'd0;
                        phase <= 1'b0;
                        if (skip_cnt != '0) begin
                            skip_cnt <= skip_cnt - 1'b1;
                            capture  <= 1'b0;
                        end else begin
                            capture     <= enable;
                            frame_start <= enable;
                        end
                    end
                end

                FRAME: begin
                    if (HREF && VSYNC) begin
                        if (capture) err_frame <= 1'b1;
                    end else if (HREF) begin
                        if (!phase) begin
                            hi    <= DATA;
                            phase <= 1'b1;
                        end else begin
                            phase <= 1'b0;
                            x     <= x_inc;
                            if (x < H_LIM && y < V_LIM) begin
                                pix_valid <= capture;
                                if (capture) begin
                                    pix_data <= {hi, DATA};
                                    pix_x    <= x;
                                    pix_y    <= y;
                                end
                            end else if (capture) begin
                                if (x >= H_LIM) err_line  <= 1'b1;
                                if (y >= V_LIM) err_frame <= 1'b1;
                            end
                        end
                    end

                    if (href_fall) begin
                        line_end <= capture;
                        if (capture && (x != H_LIM || phase)) err_line <= 1'b1;
                        x     <= 10'd0;
                        phase <= 1'b0;
                        y     <= y_inc;
                    end

                    // NOTE: non-blocking assignments let the frame-end clear of y
                    // below override the line-end increment above on a shared edge.
                    if (vs_rise) begin
                        state      <= BLANK;
                        frame_done <= capture;
                        if (capture) begin
                            if (y_end != V_LIM) err_frame <= 1'b1;
                            frame_cnt <= frame_cnt + 16'd1;
                        end
                        y <= 9'd0;
                    end
                end

                default: state <= SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_capture.sv
// Directed bench for cam_capture on a reduced 4x3 geometry with two skip
// frames; expected values are hand-derived from the stimulus.
module tb_cam_capture;

    localparam int H = 4;
    localparam int V = 3;

    logic        PCLK = 1'b0;
    logic        reset;
    logic        enable;
    logic        VSYNC;
    logic        HREF;
    logic [7:0]  DATA;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic        frame_start;
    logic        frame_done;
    logic        line_end;
    logic        err_line;
    logic        err_frame;
    logic [15:0] frame_cnt;

    cam_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .SKIP_FRAMES(2)) dut (
        .PCLK(PCLK), .reset(reset), .enable(enable), .VSYNC(VSYNC),
        .HREF(HREF), .DATA(DATA), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start),
        .frame_done(frame_done), .line_end(line_end), .err_line(err_line),
        .err_frame(err_frame), .frame_cnt(frame_cnt)
    );

    always #5 PCLK = ~PCLK;

    int cyc = 0;
    int vec_cnt = 0;
    int mis_cnt = 0;
    int n_valid = 0, n_le = 0, n_fs = 0, n_fd = 0;
    int last_x = 0, last_y = 0, stamp_valid = 0, stamp_drive = 0;
    logic [15:0] got_data [0:7][0:7];
    int          got_cnt  [0:7][0:7];

    always @(posedge PCLK) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    always @(negedge PCLK) begin
        if (pix_valid) begin
            n_valid <= n_valid + 1;
            last_x  <= int'(pix_x);
            last_y  <= int'(pix_y);
            if (pix_x < 10'd8 && pix_y < 9'd8) begin
                got_data[pix_y[2:0]][pix_x[2:0]] <= pix_data;
                got_cnt[pix_y[2:0]][pix_x[2:0]]  <= got_cnt[pix_y[2:0]][pix_x[2:0]] + 1;
            end
            if (pix_x == 10'd0 && pix_y == 9'd0) stamp_valid <= cyc;
        end
        if (line_end)    n_le <= n_le + 1;
        if (frame_start) n_fs <= n_fs + 1;
        if (frame_done)  n_fd <= n_fd + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp)
        else begin
            mis_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] byte_val(input int x, input int y, input bit lo);
        logic [7:0] hv;
        if (x == 0 && y == 0) return lo ? 8'h1F : 8'hF8;
        if (x == H - 1 && y == V - 1) return lo ? 8'hE0 : 8'h07;
        hv = {y[3:0], x[3:0]};
        return lo ? (hv ^ 8'hA5) : hv;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge PCLK);
            HREF = 1'b0;
            DATA = 8'd0;
        end
    endtask

    task automatic send_line(input int y, input int nbytes);
        for (int b = 0; b < nbytes; b++) begin
            @(negedge PCLK);
            HREF = 1'b1;
            DATA = byte_val(b / 2, y, b[0]);
            if (y == 0 && b == 1) stamp_drive = cyc;
        end
        idle(6);
    endtask

    task automatic send_frame(input int n_lines, input int bad_line, input int bad_bytes);
        for (int y = 0; y < n_lines; y++)
            send_line(y, (y == bad_line) ? bad_bytes : 2 * H);
        idle(2);
    endtask

    task automatic vsync_pulse();
        @(negedge PCLK);
        VSYNC = 1'b1;
        HREF  = 1'b0;
        repeat (3) @(negedge PCLK);
        VSYNC = 1'b0;
        idle(4);
    endtask

    task automatic do_reset();
        @(negedge PCLK);
        reset = 1'b1;
        VSYNC = 1'b0;
        HREF  = 1'b0;
        repeat (3) @(negedge PCLK);
        reset = 1'b0;
    endtask

    // Reset, then sync and discard two frames; leaves a captured frame open.
    task automatic restart();
        do_reset();
        vsync_pulse();
        send_frame(V, -1, 0);
        vsync_pulse();
        send_frame(V, -1, 0);
        vsync_pulse();
    endtask

    int s_valid, s_le, s_fs, s_fd, s_cnt;

    initial begin
        reset = 1'b1; enable = 1'b0; VSYNC = 1'b0; HREF = 1'b0; DATA = 8'd0;
        repeat (3) @(negedge PCLK);
        check("rst_pix_valid", 32'(pix_valid), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_err_line", 32'(err_line), 32'd0);
        check("rst_err_frame", 32'(err_frame), 32'd0);
        check("rst_frame_start", 32'(frame_start), 32'd0);
        reset = 1'b0;
        enable = 1'b1;

        // Partial frame before any VSYNC, then two skip frames.
        send_line(0, 2 * H);
        send_line(1, 2 * H);
        vsync_pulse();
        check("sync_discard_valid", 32'(n_valid), 32'd0);
        check("sync_discard_le", 32'(n_le), 32'd0);
        send_frame(V, -1, 0);
        vsync_pulse();
        send_frame(V, -1, 0);
        check("skip_valid", 32'(n_valid), 32'd0);
        check("skip_fs", 32'(n_fs), 32'd0);

        // First captured frame.
        vsync_pulse();
        check("cap_fs", 32'(n_fs), 32'd1);
        send_frame(V, -1, 0);
        check("cap_valid", 32'(n_valid), 32'(H * V));
        check("cap_le", 32'(n_le), 32'(V));
        check("pix_0_0", 32'(got_data[0][0]), 32'h0000F81F);
        check("pix_1_1", 32'(got_data[1][1]), 32'h000011B4);
        check("pix_last", 32'(got_data[V-1][H-1]), 32'h000007E0);
        check("last_x", 32'(last_x), 32'(H - 1));
        check("last_y", 32'(last_y), 32'(V - 1));
        check("latency", 32'(stamp_valid - stamp_drive), 32'd1);
        vsync_pulse();
        check("cap_fd", 32'(n_fd), 32'd1);
        check("cap_frame_cnt", 32'(frame_cnt), 32'd1);
        check("cap_err_line", 32'(err_line), 32'd0);
        check("cap_err_frame", 32'(err_frame), 32'd0);

        // Line 1 one pixel short.
        s_valid = n_valid;
        s_cnt   = got_cnt[2][0];
        send_frame(V, 1, 2 * H - 2);
        vsync_pulse();
        check("short_err_line", 32'(err_line), 32'd1);
        check("short_err_frame", 32'(err_frame), 32'd0);
        check("short_valid", 32'(n_valid - s_valid), 32'(H * V - 1));
        check("short_next_x0", 32'(got_cnt[2][0] - s_cnt), 32'd1);
        check("short_frame_cnt", 32'(frame_cnt), 32'd2);

        // Line 0 with an odd byte count.
        restart();
        check("restart_err_line", 32'(err_line), 32'd0);
        s_valid = n_valid;
        send_frame(V, 0, 2 * H + 1);
        vsync_pulse();
        check("odd_err_line", 32'(err_line), 32'd1);
        check("odd_valid", 32'(n_valid - s_valid), 32'(H * V));
        check("odd_err_frame", 32'(err_frame), 32'd0);

        // Frame one line short; next frame disabled.
        restart();
        s_valid = n_valid;
        s_fd    = n_fd;
        send_frame(V - 1, -1, 0);
        enable = 1'b0;
        vsync_pulse();
        check("vshort_fd", 32'(n_fd - s_fd), 32'd1);
        check("vshort_err_frame", 32'(err_frame), 32'd1);
        check("vshort_err_line", 32'(err_line), 32'd0);
        check("vshort_frame_cnt", 32'(frame_cnt), 32'd1);
        check("vshort_valid", 32'(n_valid - s_valid), 32'(H * (V - 1)));

        s_valid = n_valid; s_le = n_le; s_fs = n_fs; s_fd = n_fd;
        send_frame(V, -1, 0);
        enable = 1'b1;
        vsync_pulse();
        check("dis_valid", 32'(n_valid - s_valid), 32'd0);
        check("dis_le", 32'(n_le - s_le), 32'd0);
        check("dis_fd", 32'(n_fd - s_fd), 32'd0);
        check("dis_frame_cnt", 32'(frame_cnt), 32'd1);
        check("resume_fs", 32'(n_fs - s_fs), 32'd1);

        // enable dropped mid-frame must not truncate the frame.
        s_valid = n_valid; s_fd = n_fd;
        send_line(0, 2 * H);
        enable = 1'b0;
        send_line(1, 2 * H);
        send_line(2, 2 * H);
        idle(2);
        enable = 1'b1;
        vsync_pulse();
        check("middrop_valid", 32'(n_valid - s_valid), 32'(H * V));
        check("middrop_fd", 32'(n_fd - s_fd), 32'd1);
        check("middrop_frame_cnt", 32'(frame_cnt), 32'd2);

        // Reset in the middle of a captured frame.
        send_line(0, 2 * H);
        send_line(1, 2 * H);
        @(negedge PCLK);
        reset = 1'b1;
        @(negedge PCLK);
        check("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("midrst_err_frame", 32'(err_frame), 32'd0);
        check("midrst_pix_x", 32'(pix_x), 32'd0);
        check("midrst_pix_data", 32'(pix_data), 32'd0);
        reset = 1'b0;
        s_fs = n_fs; s_valid = n_valid;
        send_line(2, 2 * H);
        idle(2);
        vsync_pulse();
        send_frame(V, -1, 0);
        vsync_pulse();
        send_frame(V, -1, 0);
        check("midrst_skip_fs", 32'(n_fs - s_fs), 32'd0);
        check("midrst_skip_valid", 32'(n_valid - s_valid), 32'd0);
        vsync_pulse();
        check("midrst_fs", 32'(n_fs - s_fs), 32'd1);
        send_frame(V, -1, 0);
        vsync_pulse();
        check("midrst_valid", 32'(n_valid - s_valid), 32'(H * V));
        check("midrst_cnt_after", 32'(frame_cnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
        $finish;
    end

endmodule
